// File: rtl/ps2_hex_entry.sv
// rtl/ps2_hex_entry.sv - PS/2 Set-2 hex digit entry: 8-digit buffer, Enter latch, repeat filter.
module ps2_hex_entry (
  input  logic        Clock_50,
  input  logic        Resetn,
  input  logic [7:0]  PS2_code,
  input  logic        PS2_code_ready,
  input  logic        PS2_make_code,
  input  logic        Clear,
  output logic [31:0] Digits,
  output logic [3:0]  Digit_count,
  output logic [31:0] Entry_value,
  output logic        Enter_pulse,
  output logic        Key_pulse,
  output logic        Overflow_pulse
);

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_APPLY} state_t;
  typedef enum logic [2:0] {C_HEX, C_ENTER, C_BKSP, C_ESC, C_OTHER} cls_t;

  state_t      state, state_next;
  cls_t        dec_cls, cls_q;
  logic [3:0]  dec_val, val_q;
  logic [7:0]  code_q, held_code;
  logic        make_q, held, act_q, ready_prev;
  logic        rise, is_repeat;

  assign rise      = PS2_code_ready & ~ready_prev;
  assign is_repeat = held && (held_code == code_q);

  always_comb begin
    dec_cls = C_HEX;
    dec_val = 4'h0;
    case (code_q)
      8'h45: dec_val = 4'h0;
      8'h16: dec_val = 4'h1;
      8'h1E: dec_val = 4'h2;
      8'h26: dec_val = 4'h3;
      8'h25: dec_val = 4'h4;
      8'h2E: dec_val = 4'h5;
      8'h36: dec_val = 4'h6;
      8'h3D: dec_val = 4'h7;
      8'h3E: dec_val = 4'h8;
      8'h46: dec_val = 4'h9;
      8'h1C: dec_val = 4'hA;
      8'h32: dec_val = 4'hB;
      8'h21: dec_val = 4'hC;
      8'h23: dec_val = 4'hD;
      8'h24: dec_val = 4'hE;
      8'h2B: dec_val = 4'hF;
      8'h5A: dec_cls = C_ENTER;
      8'h66: dec_cls = C_BKSP;
      8'h76: dec_cls = C_ESC;
      default: dec_cls = C_OTHER;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (rise) state_next = S_DECODE;
      S_DECODE: state_next = S_APPLY;
      S_APPLY:  state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
    if (Clear) state_next = S_IDLE;
  end

  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) state <= S_IDLE;
    else         state <= state_next;
  end

  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      ready_prev     <= 1'b0;
      code_q         <= 8'h00;
      make_q         <= 1'b0;
      cls_q          <= C_OTHER;
      val_q          <= 4'h0;
      act_q          <= 1'b0;
      held           <= 1'b0;
      held_code      <= 8'h00;
      Digits         <= 32'h0;
      Digit_count    <= 4'd0;
      Entry_value    <= 32'h0;
      Enter_pulse    <= 1'b0;
      Key_pulse      <= 1'b0;
      Overflow_pulse <= 1'b0;
    end else begin
      ready_prev     <= PS2_code_ready;
      Enter_pulse    <= 1'b0;
      Key_pulse      <= 1'b0;
      Overflow_pulse <= 1'b0;
      if (state == S_IDLE && rise) begin
        code_q <= PS2_code;
        make_q <= PS2_make_code;
      end
      // Held-key tracking happens here even if Clear aborts the event this cycle.
      if (state == S_DECODE) begin
        cls_q <= dec_cls;
        val_q <= dec_val;
        act_q <= make_q && !is_repeat;
        if (make_q) begin
          if (!is_repeat) begin
            held      <= 1'b1;
            held_code <= code_q;
          end
        end else if (code_q != 8'hF0) begin
          held <= 1'b0;
        end
      end
      if (Clear) begin
        Digits      <= 32'h0;
        Digit_count <= 4'd0;
      end else if (state == S_APPLY && act_q) begin
        case (cls_q)
          C_HEX: begin
            if (Digit_count < 4'd8) begin
              Digits      <= {Digits[27:0], val_q};
              Digit_count <= Digit_count + 4'd1;
              Key_pulse   <= 1'b1;
            end else begin
              Overflow_pulse <= 1'b1;
            end
          end
          C_BKSP: begin
            if (Digit_count != 4'd0) begin
              Digits      <= {4'h0, Digits[31:4]};
              Digit_count <= Digit_count - 4'd1;
            end
          end
          C_ESC: begin
            Digits      <= 32'h0;
            Digit_count <= 4'd0;
          end
          C_ENTER: begin
            Entry_value <= Digits;
            Enter_pulse <= 1'b1;
            Digits      <= 32'h0;
            Digit_count <= 4'd0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/ps2_hex_entry.md
# ps2_hex_entry

Hex-number entry stage downstream of the PS/2 byte assembler. Consumes its assembled scan code, ready and make/break flags, decodes Set-2 scan codes for 0-9/A-F plus Enter, Backspace and Esc, and maintains an 8-digit entry buffer for the 7-segment display path. Enter latches the buffer as a 32-bit value. Typematic repeats of a held key are suppressed until that key's break code.

## Interface
- No parameters.
- Clock_50  in  1  system clock, 50 MHz
- Resetn  in  1  asynchronous, active-low reset
- PS2_code  in  8  last assembled scan code
- PS2_code_ready  in  1  level; a 0->1 transition marks a new code
- PS2_make_code  in  1  1 = make code, 0 = break-related code (F0 prefix or released key)
- Clear  in  1  synchronous clear of the entry buffer, highest priority
- Digits  out  32  8 nibbles; [3:0] is the most recently entered digit
- Digit_count  out  4  filled digits, 0..8
- Entry_value  out  32  Digits captured on Enter
- Enter_pulse  out  1  one-cycle strobe when Entry_value updates
- Key_pulse  out  1  one-cycle strobe when a hex digit is accepted
- Overflow_pulse  out  1  one-cycle strobe when a digit is rejected because the buffer is full

## Operation
- Reset values: all outputs 0. Internal held flag 0, held code 00, FSM S_IDLE, previous-ready register 0.
- Edge detection: ready_prev <= PS2_code_ready every cycle. rise = PS2_code_ready & ~ready_prev.
- FSM states:
  - S_IDLE: on rise, capture PS2_code and PS2_make_code, go to S_DECODE.
  - S_DECODE: register the class (HEX+value, ENTER, BKSP, ESC, OTHER) and the repeat flag, go to S_APPLY.
  - S_APPLY: update state, fire the pulses, go to S_IDLE.
- A rise seen outside S_IDLE is dropped.
- Decode table (Set 2):
  - Digits 0-9: 0=45, 1=16, 2=1E, 3=26, 4=25, 5=2E, 6=36, 7=3D, 8=3E, 9=46.
  - Hex letters A-F: A=1C, B=32, C=21, D=23, E=24, F=2B.
  - Commands: ENTER=5A, BKSP=66, ESC=76. Any other code is OTHER.
- Break handling (make=0):
  - Code F0: ignored.
  - Any other code: held flag cleared. No buffer change.
- Repeat filter (make=1):
  - If held=1 and code == held code, the event is ignored entirely, with no pulses.
  - Otherwise held <= 1 and held code <= code, then the action is applied.
- Actions, applied in S_APPLY:
  - HEX, count<8: Digits <= {Digits[27:0], value}, count+1, Key_pulse.
  - HEX, count=8: no change, Overflow_pulse.
  - BKSP: Digits <= {4'h0, Digits[31:4]}, count-1. No-op at count 0.
  - ESC: Digits <= 0, count <= 0.
  - ENTER: Entry_value <= Digits, Enter_pulse, then Digits <= 0 and count <= 0 in the same cycle. Applies at count 0 too, giving Entry_value = 0.
  - OTHER: no change, though it still updates the held state.
- Clear=1 on any cycle:
  - Digits and count go to 0. FSM goes to S_IDLE, aborting any in-flight event. Pulses are forced to 0.
  - Held state and Entry_value are unchanged.
- Count arithmetic is 4-bit unsigned and never wraps: it saturates at 8 and floors at 0.

## Timing
- Let edge k be the first clock edge that samples PS2_code_ready=1 with ready_prev=0.
- Edge k: FSM enters S_DECODE with the code captured.
- Edge k+1: FSM enters S_APPLY.
- Edge k+2: Digits, Digit_count and Entry_value update. Pulses go high for exactly the cycle between edge k+2 and edge k+3. FSM returns to S_IDLE.
- Latency from sampled rise to visible output: 2 cycles.
- Throughput: one code per 3 cycles. PS/2 byte spacing (>1 ms) exceeds this by orders of magnitude, but a rise 1-2 cycles after an accepted one is still dropped.
- Clear asserted at edge k+1 or k+2 cancels the event: no pulse, buffer is 0.
- Resetn asserted mid-event returns every output and register to its reset value asynchronously. Deassertion is synchronous to Clock_50.
- A constant-high PS2_code_ready produces one event only.

## Test plan
- Reset, then make codes 16, 1E, 26 with breaks between -> Digits=00000123, Digit_count=3, three Key_pulse strobes each 2 cycles after the rise.
- Make 1C held with three repeated rises, then F0 and 1C break, then 1C again -> only two Key_pulse strobes, Digits=000000AA.
- Nine distinct hex keys (press/release each), first 1 through 8, then 9 -> Digits=12345678, count=8, one Overflow_pulse, no ninth Key_pulse.
- Keys 2B, 24 then 66 -> Digits=0000000F, count=1. Then 5A -> Entry_value=0000000F, Enter_pulse once, Digits=0, count=0. Then 66 at count 0 -> no change.
- Key 45 then Clear pulsed on edge k+1 of a second key 46 -> no Key_pulse, Digits=0, count=0. Held state updated so an immediate repeat of 46 is ignored.
- Resetn low during S_APPLY after digits 3D, 3E -> all outputs 0 immediately. Next 76 (Esc) and unknown code 12 -> no pulses, Digits=0.
